// File: rtl/axis_pwm_driver.sv
// Complementary dead-time PWM driver for an H-bridge, fed by a signed AXI-Stream effort word.
// New effort words are latched into a one-deep holding register and applied only at period boundaries.
module axis_pwm_driver #(
    parameter int W        = 16,
    parameter int PERIOD   = 1000,
    parameter int DEADTIME = 10
) (
    input  logic         clk_in1,
    input  logic         reset,
    input  logic [W-1:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic         enable,
    output logic         pwm_hi,
    output logic         pwm_lo,
    output logic         dir,
    output logic         period_tick,
    output logic         sat_flag
);

    localparam int CW = $clog2(PERIOD + DEADTIME + 1);
    localparam int MW = (W > CW) ? W : CW;

    localparam logic [CW-1:0] DT_C   = CW'(DEADTIME);
    localparam logic [CW-1:0] PER_C  = CW'(PERIOD);
    localparam logic [CW-1:0] LAST_C = CW'(PERIOD - 1);
    localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  MAX_POS = {1'b0, {(W-1){1'b1}}};

    logic [CW-1:0] cnt;
    logic [CW-1:0] duty;
    logic [W-1:0]  hold;
    logic          pending;

    logic          last_cnt;
    logic          xfer;
    logic          load;
    logic          pending_next;
    logic [W-1:0]  mag;
    logic [MW-1:0] mag_w;
    logic          sat_next;
    logic [CW-1:0] duty_next;
    logic [CW-1:0] lo_start;
    logic          hi_next;
    logic          lo_next;

    // Handshake: s_axis_tready is the registered complement of pending. A word
    // transfers on any edge where s_axis_tvalid && s_axis_tready; the upstream
    // must then hold tdata/tvalid stable until tready returns after the next load.
    assign last_cnt     = (cnt == LAST_C);
    assign xfer         = s_axis_tvalid && s_axis_tready;
    assign load         = last_cnt && pending;
    assign pending_next = xfer ? 1'b1 : (load ? 1'b0 : pending);

    // Magnitude of the held word; the most negative code has no positive twin.
    always_comb begin
        mag = hold;
        if (hold[W-1]) begin
            mag = (hold == MIN_NEG) ? MAX_POS : (~hold + W'(1));
        end
    end

    assign mag_w     = MW'(mag);
    assign sat_next  = (mag_w > MW'(PERIOD));
    assign duty_next = sat_next ? PER_C : mag_w[CW-1:0];

    // duty <= PERIOD, so duty + DEADTIME always fits in CW bits.
    assign lo_start = duty + DT_C;
    assign hi_next  = enable && (cnt >= DT_C) && (cnt < duty);
    assign lo_next  = enable && (cnt >= lo_start) && (cnt < PER_C);

    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            duty          <= '0;
            hold          <= '0;
            pending       <= 1'b0;
            s_axis_tready <= 1'b0;
            dir           <= 1'b0;
            sat_flag      <= 1'b0;
            pwm_hi        <= 1'b0;
            pwm_lo        <= 1'b0;
            period_tick   <= 1'b0;
        end else begin
            cnt           <= last_cnt ? '0 : cnt + CW'(1);
            pending       <= pending_next;
            s_axis_tready <= !pending_next;
            if (xfer) begin
                hold <= s_axis_tdata;
            end
            if (load) begin
                duty     <= duty_next;
                sat_flag <= sat_next;
                dir      <= hold[W-1];
            end
            pwm_hi      <= hi_next;
            pwm_lo      <= lo_next;
            period_tick <= last_cnt;
        end
    end

endmodule

// File: tb/tb_axis_pwm_driver.sv
// Directed bench for axis_pwm_driver: table of effort words with hand-computed
// per-period gate windows, plus sequences for streaming, boundary timing, enable and reset.
module tb_axis_pwm_driver;

    localparam int W  = 16;
    localparam int P  = 1000;
    localparam int DT = 10;

    logic         clk_in1;
    logic         reset;
    logic [W-1:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         enable;
    logic         pwm_hi;
    logic         pwm_lo;
    logic         dir;
    logic         period_tick;
    logic         sat_flag;

    axis_pwm_driver #(.W(W), .PERIOD(P), .DEADTIME(DT)) dut (
        .clk_in1       (clk_in1),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .enable        (enable),
        .pwm_hi        (pwm_hi),
        .pwm_lo        (pwm_lo),
        .dir           (dir),
        .period_tick   (period_tick),
        .sat_flag      (sat_flag)
    );

    // clock / watchdog
    initial clk_in1 = 1'b0;
    always #5 clk_in1 = ~clk_in1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] effort;
        int hi_cnt, hi_first, hi_last;
        int lo_cnt, lo_first, lo_last;
        int dir_e, sat_e;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    int m_hi_cnt, m_hi_first, m_hi_last;
    int m_lo_cnt, m_lo_first, m_lo_last;
    int m_overlap, m_tick_bad, m_dir, m_sat;

    vec_t vecs[12];

    function automatic vec_t mk(input int e, input int hc, input int hf, input int hl,
                                input int lc, input int lf, input int ll,
                                input int d, input int s);
        vec_t v;
        v.effort = W'(e);
        v.hi_cnt = hc; v.hi_first = hf; v.hi_last = hl;
        v.lo_cnt = lc; v.lo_first = lf; v.lo_last = ll;
        v.dir_e = d; v.sat_e = s;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // driver: present a word and return at the negedge after it was accepted
    task automatic send_word(input logic [W-1:0] v, input bit drop);
        int g;
        g = 0;
        s_axis_tdata  = v;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && g < 3*P) begin
            @(negedge clk_in1);
            g++;
        end
        check("send_ready_seen", s_axis_tready, 1);
        @(negedge clk_in1);
        if (drop) s_axis_tvalid = 1'b0;
    endtask

    // monitor: wait for a period_tick, then record one full period (sample i reflects cnt=i)
    task automatic measure_period();
        int g;
        g = 0;
        while (!period_tick && g < 2*P) begin
            @(negedge clk_in1);
            g++;
        end
        check("tick_found", period_tick, 1);
        m_hi_cnt = 0; m_hi_first = -1; m_hi_last = -1;
        m_lo_cnt = 0; m_lo_first = -1; m_lo_last = -1;
        m_overlap = 0; m_tick_bad = 0; m_dir = 0; m_sat = 0;
        for (int i = 0; i < P; i++) begin
            @(negedge clk_in1);
            if (pwm_hi) begin
                m_hi_cnt++;
                if (m_hi_first < 0) m_hi_first = i;
                m_hi_last = i;
            end
            if (pwm_lo) begin
                m_lo_cnt++;
                if (m_lo_first < 0) m_lo_first = i;
                m_lo_last = i;
            end
            if (pwm_hi && pwm_lo) m_overlap++;
            if (period_tick != (i == P-1)) m_tick_bad++;
            if (i == P/2) begin
                m_dir = dir;
                m_sat = sat_flag;
            end
        end
    endtask

    task automatic check_period(input vec_t v, input string tag);
        check({tag, ".hi_cnt"},   m_hi_cnt,   v.hi_cnt);
        check({tag, ".hi_first"}, m_hi_first, v.hi_first);
        check({tag, ".hi_last"},  m_hi_last,  v.hi_last);
        check({tag, ".lo_cnt"},   m_lo_cnt,   v.lo_cnt);
        check({tag, ".lo_first"}, m_lo_first, v.lo_first);
        check({tag, ".lo_last"},  m_lo_last,  v.lo_last);
        check({tag, ".overlap"},  m_overlap,  0);
        check({tag, ".tick_bad"}, m_tick_bad, 0);
        check({tag, ".dir"},      m_dir,      v.dir_e);
        check({tag, ".sat"},      m_sat,      v.sat_e);
    endtask

    initial begin
        vec_t v_idle, v100, v200, v300, vneg700;
        int acc, gate_hits, g;
        logic [W-1:0] stream_vals[3];

        vecs[0]  = mk(500,    490, 10, 499, 490, 510, 999, 0, 0);
        vecs[1]  = mk(-32768, 990, 10, 999,   0,  -1,  -1, 1, 1);
        vecs[2]  = mk(-250,   240, 10, 249, 740, 260, 999, 1, 0);
        vecs[3]  = mk(5,        0, -1,  -1, 985,  15, 999, 0, 0);
        vecs[4]  = mk(10,       0, -1,  -1, 980,  20, 999, 0, 0);
        vecs[5]  = mk(11,       1, 10,  10, 979,  21, 999, 0, 0);
        vecs[6]  = mk(990,    980, 10, 989,   0,  -1,  -1, 0, 0);
        vecs[7]  = mk(995,    985, 10, 994,   0,  -1,  -1, 0, 0);
        vecs[8]  = mk(1000,   990, 10, 999,   0,  -1,  -1, 0, 0);
        vecs[9]  = mk(1001,   990, 10, 999,   0,  -1,  -1, 0, 1);
        vecs[10] = mk(32767,  990, 10, 999,   0,  -1,  -1, 0, 1);
        vecs[11] = mk(-1,       0, -1,  -1, 989,  11, 999, 1, 0);
        v_idle   = mk(0,        0, -1,  -1, 990,  10, 999, 0, 0);
        v100     = mk(100,     90, 10,  99, 890, 110, 999, 0, 0);
        v200     = mk(200,    190, 10, 199, 790, 210, 999, 0, 0);
        v300     = mk(300,    290, 10, 299, 690, 310, 999, 0, 0);
        vneg700  = mk(-700,   690, 10, 699, 290, 710, 999, 1, 0);
        stream_vals[0] = 16'd100;
        stream_vals[1] = 16'd200;
        stream_vals[2] = 16'd300;

        // reset release with no traffic
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        enable = 1'b1;
        repeat (3) @(negedge clk_in1);
        check("rst.tready", s_axis_tready, 0);
        check("rst.pwm_lo", pwm_lo, 0);
        reset = 1'b0;
        check("rel.tready_before_edge", s_axis_tready, 0);
        @(negedge clk_in1);
        check("rel.tready_after_edge", s_axis_tready, 1);
        check("rel.pwm_hi", pwm_hi, 0);
        measure_period();
        check_period(v_idle, "idle");

        // table-driven effort words
        for (int i = 0; i < 12; i++) begin
            send_word(vecs[i].effort, 1'b1);
            check($sformatf("vec%0d.tready_low", i), s_axis_tready, 0);
            measure_period();
            check($sformatf("vec%0d.tready_back", i), s_axis_tready, 1);
            check_period(vecs[i], $sformatf("vec%0d", i));
        end

        // streaming with tvalid held high: one word per period, in order
        acc = 0;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    send_word(stream_vals[k], k == 2);
                    acc++;
                end
            end
            begin
                @(negedge clk_in1);
                measure_period();
                check_period(v100, "stream0");
                measure_period();
                check_period(v200, "stream1");
                measure_period();
                check_period(v300, "stream2");
            end
        join
        check("stream.accepted", acc, 3);
        measure_period();
        check_period(v300, "stream.hold");

        // word accepted on the cnt==PERIOD-1 edge is deferred one period
        repeat (P-1) @(negedge clk_in1);
        s_axis_tdata = W'(-700);
        s_axis_tvalid = 1'b1;
        @(negedge clk_in1);
        s_axis_tvalid = 1'b0;
        check("late.tick", period_tick, 1);
        check("late.tready", s_axis_tready, 0);
        measure_period();
        check_period(v300, "late.old");
        measure_period();
        check_period(vneg700, "late.new");

        // enable dropped mid-period
        repeat (P/2) @(negedge clk_in1);
        check("en.hi_before", pwm_hi, 1);
        enable = 1'b0;
        @(negedge clk_in1);
        check("en.hi_off", pwm_hi, 0);
        check("en.lo_off", pwm_lo, 0);
        check("en.dir_kept", dir, 1);
        gate_hits = 0;
        repeat (600) begin
            @(negedge clk_in1);
            if (pwm_hi || pwm_lo) gate_hits++;
        end
        check("en.gates_quiet", gate_hits, 0);
        check("en.tready", s_axis_tready, 1);
        enable = 1'b1;

        // reset in the middle of an active-high window
        g = 0;
        while (!period_tick && g < 2*P) begin
            @(negedge clk_in1);
            g++;
        end
        check("rst6.tick_found", period_tick, 1);
        repeat (400) @(negedge clk_in1);
        check("rst6.hi_before", pwm_hi, 1);
        reset = 1'b1;
        #1;
        check("rst6.pwm_hi", pwm_hi, 0);
        check("rst6.pwm_lo", pwm_lo, 0);
        check("rst6.dir", dir, 0);
        check("rst6.sat", sat_flag, 0);
        check("rst6.tick", period_tick, 0);
        check("rst6.tready", s_axis_tready, 0);
        @(negedge clk_in1);
        reset = 1'b0;
        measure_period();
        check_period(v_idle, "rst6.after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
